// File: rtl/perf_pkg.sv
// Shared definitions for the performance-event counter: channel counting
// modes and the register-map layout, expressed as functions of the
// channel count so the top level and any software header agree.
package perf_pkg;

  typedef enum logic {
    PERF_LEVEL = 1'b0,
    PERF_EDGE  = 1'b1
  } perf_mode_e;

  // The live bank always starts at address zero; the argument is kept so
  // every offset function has the same shape.
  function automatic logic [31:0] LIVE_BASE(input int num_ch);
    return 32'(num_ch - num_ch);
  endfunction

  function automatic logic [31:0] SNAP_BASE(input int num_ch);
    return 32'(num_ch);
  endfunction

  function automatic logic [31:0] OVF_ADDR(input int num_ch);
    return 32'(2 * num_ch);
  endfunction

  function automatic logic [31:0] CYC_ADDR(input int num_ch);
    return 32'(2 * num_ch + 1);
  endfunction

endpackage

// File: rtl/perf_cnt_lane.sv
// One event channel: edge register, event counter, sticky overflow flag
// and the snapshot register that freezes the counter on request.
module perf_cnt_lane
  import perf_pkg::*;
#(
  parameter int         CNT_WIDTH = 32,
  parameter perf_mode_e MODE      = PERF_EDGE,
  parameter bit         SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 evt,
  input  logic                 en,
  input  logic                 clear,
  input  logic                 snapshot,
  output logic [CNT_WIDTH-1:0] count,
  output logic [CNT_WIDTH-1:0] snap,
  output logic                 ovf
);

  logic evt_d;
  logic hit;
  logic at_max;

  assign at_max = &count;

  // Decide whether this cycle is a countable event for the channel's mode.
  always_comb begin
    hit = 1'b0;
    if (en) begin
      hit = (MODE == PERF_EDGE) ? (evt & ~evt_d) : evt;
    end
  end

  // Counter, snapshot and flag update; snapshot samples the pre-update
  // value, and clear drops any same-cycle event but spares a fresh snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_d <= 1'b0;
      count <= '0;
      snap  <= '0;
      ovf   <= 1'b0;
    end else begin
      evt_d <= evt;
      if (snapshot) begin
        snap <= count;
      end else if (clear) begin
        snap <= '0;
      end
      if (clear) begin
        count <= '0;
        ovf   <= 1'b0;
      end else if (hit) begin
        if (at_max) begin
          ovf   <= 1'b1;
          count <= SATURATE ? count : '0;
        end else begin
          count <= count + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/perf_event_counter.sv
// N-channel performance-event counter with snapshot bank, sticky overflow
// flags, a free-running cycle counter and a one-cycle-latency read port.
module perf_event_counter
  import perf_pkg::*;
#(
  parameter int                NUM_CH     = 4,
  parameter int                CNT_WIDTH  = 32,
  parameter logic [NUM_CH-1:0] EDGE_MODE  = {NUM_CH{1'b1}},
  parameter bit                SATURATE   = 1'b0,
  parameter int                ADDR_WIDTH = $clog2(2*NUM_CH+2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     event_i,
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic                  clear,
  input  logic                  snapshot,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  rd_valid
);

  logic [CNT_WIDTH-1:0] live [NUM_CH];
  logic [CNT_WIDTH-1:0] snap [NUM_CH];
  logic [NUM_CH-1:0]    ovf;
  logic [CNT_WIDTH-1:0] cyc;
  logic [CNT_WIDTH-1:0] rd_mux;
  logic [31:0]          addr;

  assign addr = 32'(rd_addr);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
    perf_cnt_lane #(
      .CNT_WIDTH (CNT_WIDTH),
      .MODE      (perf_mode_e'(EDGE_MODE[n])),
      .SATURATE  (SATURATE)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .evt      (event_i[n]),
      .en       (ch_en[n]),
      .clear    (clear),
      .snapshot (snapshot),
      .count    (live[n]),
      .snap     (snap[n]),
      .ovf      (ovf[n])
    );
  end

  // Free-running cycle counter, ungated by channel enables, same wrap or
  // saturate behaviour as the channels but without a flag.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cyc <= '0;
    end else if (&cyc) begin
      cyc <= SATURATE ? cyc : '0;
    end else begin
      cyc <= cyc + CNT_WIDTH'(1);
    end
  end

  // Register-map decode of the current (pre-update) state.
  always_comb begin
    rd_mux = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (addr == LIVE_BASE(NUM_CH) + 32'(n)) rd_mux = live[n];
      if (addr == SNAP_BASE(NUM_CH) + 32'(n)) rd_mux = snap[n];
    end
    if (addr == OVF_ADDR(NUM_CH)) rd_mux[NUM_CH-1:0] = ovf;
    if (addr == CYC_ADDR(NUM_CH)) rd_mux = cyc;
  end

  // Read port: data registered on an accepted read and held until the next,
  // valid pulses for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_mux;
      end
    end
  end

endmodule
